// File: rtl/irrigation_pkg.sv
// rtl/irrigation_pkg.sv - shared state type, sensor check and stats width for irrigation_sequencer
package irrigation_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SPRINKLE,
        DRIP,
        COOLDOWN,
        FAULT
    } irr_state_t;

    localparam int STATS_W = 16;

    // Water cannot be above a sensor while below the one beneath it.
    function automatic logic sensor_inconsistent(input logic low, input logic mid, input logic high);
        return (mid & ~low) | (high & ~mid);
    endfunction

endpackage

// File: rtl/tick_timer.sv
// rtl/tick_timer.sv - loadable tick-driven down-counter shared by the timed irrigation states
module tick_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    output logic             expire
);

    logic [CNT_W-1:0] count;

    // A load wins over a same-cycle tick, so the entry cycle never consumes a tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (tick && count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign expire = tick && (count == CNT_W'(1));

endmodule

// File: rtl/irrigation_sequencer.sv
// rtl/irrigation_sequencer.sv - timed, debounced tank/irrigation controller (IRRIGATION_STATS_EN adds cycle_count)
module irrigation_sequencer
    import irrigation_pkg::*;
#(
    parameter int SPRINKLE_TIME  = 30,
    parameter int DRIP_TIME      = 60,
    parameter int COOLDOWN_TIME  = 10,
    parameter int FAULT_DEBOUNCE = 3,
    parameter int CNT_W          = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick,
    input  logic               low,
    input  logic               mid,
    input  logic               high,
    input  logic               Us,
    input  logic               Ua,
    input  logic               T,
    output logic               water_supply,
    output logic               error,
    output logic               alarme,
    output logic               asp,
    output logic               got
`ifdef IRRIGATION_STATS_EN
    ,
    output logic [STATS_W-1:0] cycle_count
`endif
);

    localparam logic [CNT_W-1:0] SPR_N = (SPRINKLE_TIME == 0)  ? CNT_W'(1) : CNT_W'(SPRINKLE_TIME);
    localparam logic [CNT_W-1:0] DRP_N = (DRIP_TIME == 0)      ? CNT_W'(1) : CNT_W'(DRIP_TIME);
    localparam logic [CNT_W-1:0] CD_N  = (COOLDOWN_TIME == 0)  ? CNT_W'(1) : CNT_W'(COOLDOWN_TIME);
    localparam logic [CNT_W-1:0] DEB_N = (FAULT_DEBOUNCE == 0) ? CNT_W'(1) : CNT_W'(FAULT_DEBOUNCE);

    logic [4:0] sync1, sync2;
    logic       ua_meta, ua_s_unused;
    logic       low_s, mid_s, high_s, us_s, t_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1       <= '0;
            sync2       <= '0;
            ua_meta     <= 1'b0;
            ua_s_unused <= 1'b0;
        end else begin
            sync1       <= {low, mid, high, Us, T};
            sync2       <= sync1;
            ua_meta     <= Ua;
            ua_s_unused <= ua_meta;
        end
    end

    assign low_s  = sync2[4];
    assign mid_s  = sync2[3];
    assign high_s = sync2[2];
    assign us_s   = sync2[1];
    assign t_s    = sync2[0];

    logic             inc;
    logic             error_nxt;
    logic [CNT_W-1:0] deb_cnt, deb_nxt;

    // error_nxt feeds the FSM directly so error and FAULT appear on the same edge.
    always_comb begin
        inc       = sensor_inconsistent(low_s, mid_s, high_s);
        error_nxt = error;
        deb_nxt   = deb_cnt;
        if (tick) begin
            if (inc != error) begin
                if (deb_cnt + CNT_W'(1) == DEB_N) begin
                    error_nxt = ~error;
                    deb_nxt   = '0;
                end else begin
                    deb_nxt = deb_cnt + CNT_W'(1);
                end
            end else begin
                deb_nxt = '0;
            end
        end
    end

    irr_state_t       state, state_nxt;
    logic             t_load, t_expire;
    logic [CNT_W-1:0] t_value;

    tick_timer #(.CNT_W(CNT_W)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick   (tick),
        .load   (t_load),
        .value  (t_value),
        .expire (t_expire)
    );

    always_comb begin
        state_nxt = state;
        t_load    = 1'b0;
        t_value   = CD_N;
        if (error_nxt) begin
            state_nxt = FAULT;
        end else begin
            case (state)
                IDLE: begin
                    if (us_s & low_s & mid_s & ~t_s) begin
                        state_nxt = SPRINKLE;
                        t_load    = 1'b1;
                        t_value   = SPR_N;
                    end else if (us_s & low_s) begin
                        state_nxt = DRIP;
                        t_load    = 1'b1;
                        t_value   = DRP_N;
                    end
                end
                SPRINKLE: begin
                    if (t_expire | ~us_s | ~low_s | ~mid_s) begin
                        state_nxt = COOLDOWN;
                        t_load    = 1'b1;
                    end
                end
                DRIP: begin
                    if (t_expire | ~us_s | ~low_s) begin
                        state_nxt = COOLDOWN;
                        t_load    = 1'b1;
                    end
                end
                COOLDOWN: begin
                    if (t_expire) begin
                        state_nxt = IDLE;
                    end
                end
                FAULT: begin
                    state_nxt = COOLDOWN;
                    t_load    = 1'b1;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            error        <= 1'b0;
            deb_cnt      <= '0;
            water_supply <= 1'b0;
            alarme       <= 1'b0;
            asp          <= 1'b0;
            got          <= 1'b0;
        end else begin
            state   <= state_nxt;
            error   <= error_nxt;
            deb_cnt <= deb_nxt;
            asp     <= (state_nxt == SPRINKLE);
            got     <= (state_nxt == DRIP);
            if (state_nxt == FAULT) begin
                water_supply <= 1'b0;
                alarme       <= 1'b1;
            end else begin
                alarme <= us_s & ~low_s;
                // Fill between mid and high: start below mid, stop at high, hold in between.
                if (high_s) begin
                    water_supply <= 1'b0;
                end else if (!mid_s) begin
                    water_supply <= 1'b1;
                end
            end
        end
    end

`ifdef IRRIGATION_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_count <= '0;
        end else if ((state == SPRINKLE || state == DRIP) && state_nxt == COOLDOWN
                     && cycle_count != {STATS_W{1'b1}}) begin
            cycle_count <= cycle_count + STATS_W'(1);
        end
    end
`endif

endmodule
